// File: rtl/gate_pipe_unit.sv
// gate_pipe_unit: pipelined eight-op bitwise gate with valid/ready
// handshakes and saturating transfer statistics.
module gate_pipe_unit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic             y_any,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] ones_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              adv;
  logic              out_xfer;
  logic [WIDTH-1:0]  res;
  logic [WIDTH-1:0]  dat_q [STAGES];
  logic [WIDTH-1:0]  dat_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              all_q;
  logic              all_d;
  logic              any_q;
  logic              any_d;
  logic [CNT_W-1:0]  xfer_cnt_q;
  logic [CNT_W-1:0]  xfer_cnt_d;
  logic [CNT_W-1:0]  ones_cnt_q;
  logic [CNT_W-1:0]  ones_cnt_d;

  // Whole pipe shifts or whole pipe holds; bubbles are not squeezed out.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;
  assign out_xfer = vld_q[STAGES-1] && out_ready;

  always_comb begin
    unique case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~(a & b);
      3'd4: res = ~(a | b);
      3'd5: res = ~(a ^ b);
      3'd6: res = a & ~b;
      3'd7: res = a;
    endcase
  end

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (adv) begin
      dat_d[0] = res;
      vld_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
        dat_d[i] = dat_q[i-1];
        vld_d[i] = vld_q[i-1];
      end
    end
    // Reductions follow the data entering the last stage.
    all_d = &dat_d[STAGES-1];
    any_d = |dat_d[STAGES-1];
  end

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    ones_cnt_d = ones_cnt_q;
    if (cnt_clr) begin
      xfer_cnt_d = '0;
      ones_cnt_d = '0;
    end else if (out_xfer) begin
      if (xfer_cnt_q != CNT_MAX)
        xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      if ((&dat_q[STAGES-1]) && (ones_cnt_q != CNT_MAX))
        ones_cnt_d = ones_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        dat_q[i] <= '0;
      vld_q      <= '0;
      all_q      <= 1'b0;
      any_q      <= 1'b0;
      xfer_cnt_q <= '0;
      ones_cnt_q <= '0;
    end else begin
      dat_q      <= dat_d;
      vld_q      <= vld_d;
      all_q      <= all_d;
      any_q      <= any_d;
      xfer_cnt_q <= xfer_cnt_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign y         = dat_q[STAGES-1];
  assign y_all     = all_q;
  assign y_any     = any_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign ones_cnt  = ones_cnt_q;

endmodule

// File: tb/tb_gate_pipe_unit.sv
// Directed bench for gate_pipe_unit: main build WIDTH=8 STAGES=2 CNT_W=4,
// plus STAGES=1 and STAGES=4 builds sharing the operand stream.
module tb_gate_pipe_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       out_ready;
  logic       cnt_clr;

  logic       in_ready, out_valid, y_all, y_any;
  logic [7:0] y;
  logic [3:0] xfer_cnt, ones_cnt;

  logic       s1_in_ready, s1_out_valid, s1_y_all, s1_y_any;
  logic [7:0] s1_y;
  logic [3:0] s1_xfer, s1_ones;
  logic       s4_in_ready, s4_out_valid, s4_y_all, s4_y_any;
  logic [7:0] s4_y;
  logic [3:0] s4_xfer, s4_ones;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_pipe_unit #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_all(y_all), .y_any(y_any), .cnt_clr(cnt_clr),
    .xfer_cnt(xfer_cnt), .ones_cnt(ones_cnt)
  );

  gate_pipe_unit #(.WIDTH(8), .STAGES(1), .CNT_W(4)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s1_in_ready),
    .a(a), .b(b), .op(op), .out_valid(s1_out_valid), .out_ready(1'b1),
    .y(s1_y), .y_all(s1_y_all), .y_any(s1_y_any), .cnt_clr(cnt_clr),
    .xfer_cnt(s1_xfer), .ones_cnt(s1_ones)
  );

  gate_pipe_unit #(.WIDTH(8), .STAGES(4), .CNT_W(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s4_in_ready),
    .a(a), .b(b), .op(op), .out_valid(s4_out_valid), .out_ready(1'b1),
    .y(s4_y), .y_all(s4_y_all), .y_any(s4_y_any), .cnt_clr(cnt_clr),
    .xfer_cnt(s4_xfer), .ones_cnt(s4_ones)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp1 [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF,
                           8'h03, 8'h33, 8'hC0, 8'hF0};

  initial begin
    int sent, rcv, stalls, idx;

    // reset with an offered input that must not be captured
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #2;
    chk("rst_in_ready_during", in_ready, 1);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_y_all", y_all, 0);
    chk("rst_y_any", y_any, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_ones", ones_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_nocap1", out_valid, 0);
    tick();
    chk("rst_nocap2", out_valid, 0);

    // scenario 1: all ops, three pipeline depths
    a = 8'hF0; b = 8'h3C;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      op = 3'(c);
      tick();
      idx = c - 1;
      if (idx >= 0 && idx < 8) begin
        chk("s1_ov", out_valid, 1);
        chk("s1_y", y, exp1[idx]);
        chk("s1_all", y_all, 0);
        chk("s1_any", y_any, 1);
      end else begin
        chk("s1_ov_idle", out_valid, 0);
      end
      idx = c;
      if (idx < 8) begin
        chk("st1_ov", s1_out_valid, 1);
        chk("st1_y", s1_y, exp1[idx]);
      end else begin
        chk("st1_ov_idle", s1_out_valid, 0);
      end
      idx = c - 3;
      if (idx >= 0 && idx < 8) begin
        chk("st4_ov", s4_out_valid, 1);
        chk("st4_y", s4_y, exp1[idx]);
        chk("st4_any", s4_y_any, 1);
      end else begin
        chk("st4_ov_idle", s4_out_valid, 0);
      end
    end
    chk("s1_xfer", xfer_cnt, 8);
    chk("s1_ones", ones_cnt, 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_xfer", xfer_cnt, 0);

    // scenario 2: stream of 10 with a 3-cycle downstream stall
    sent = 0; rcv = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      in_valid = (sent < 10);
      a = 8'(sent + 1); b = 8'h00; op = 3'd7;
      out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        chk("s2_stall_in_ready", in_ready, 0);
        chk("s2_stall_y", y, 32'(rcv + 1));
      end
      if (out_valid && out_ready) begin
        chk("s2_y", y, 32'(rcv + 1));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("s2_rcv", rcv, 10);
    chk("s2_sent", sent, 10);
    chk("s2_stalls", stalls, 3);
    chk("s2_xfer", xfer_cnt, 10);
    chk("s2_ones", ones_cnt, 0);
    chk("s2_drained", out_valid, 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;

    // scenario 3: 5 all-ones results, then 3 zero results
    a = 8'hFF; b = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      op = (c < 5) ? 3'd0 : 3'd2;
      tick();
      idx = c - 1;
      if (idx >= 0 && idx < 8) begin
        chk("s3_ov", out_valid, 1);
        chk("s3_y", y, (idx < 5) ? 8'hFF : 8'h00);
        chk("s3_all", y_all, (idx < 5) ? 1 : 0);
        chk("s3_any", y_any, (idx < 5) ? 1 : 0);
      end
    end
    chk("s3_xfer", xfer_cnt, 8);
    chk("s3_ones", ones_cnt, 5);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;

    // scenario 4: saturation at 15, then clear against a live transfer
    a = 8'hFF; b = 8'hFF; op = 3'd0; in_valid = 1'b1;
    for (int c = 0; c < 22; c++) tick();
    chk("s4_xfer_sat", xfer_cnt, 15);
    chk("s4_ones_sat", ones_cnt, 15);
    cnt_clr = 1'b1;
    #1;
    chk("s4_coincident", out_valid && out_ready, 1);
    tick();
    chk("s4_clr_xfer", xfer_cnt, 0);
    chk("s4_clr_ones", ones_cnt, 0);
    cnt_clr = 1'b0; in_valid = 1'b0;
    tick();
    chk("s4_resume_xfer", xfer_cnt, 1);
    chk("s4_resume_ones", ones_cnt, 1);
    tick();
    tick();

    // scenario 5: reset with work in flight
    a = 8'h12; b = 8'h34; op = 3'd1; in_valid = 1'b1;
    tick();
    rst = 1'b1; a = 8'h56;
    tick();
    chk("s5_ov", out_valid, 0);
    chk("s5_xfer", xfer_cnt, 0);
    chk("s5_ones", ones_cnt, 0);
    chk("s5_in_ready", in_ready, 1);
    rst = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("s5_flush", out_valid, 0);
    end
    a = 8'h0F; b = 8'hF0; op = 3'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s5_lat_early", out_valid, 0);
    tick();
    chk("s5_lat_ov", out_valid, 1);
    chk("s5_y", y, 8'hFF);
    chk("s5_all", y_all, 1);
    chk("s5_any", y_any, 1);
    tick();
    chk("s5_xfer_after", xfer_cnt, 1);
    chk("s5_ones_after", ones_cnt, 1);
    chk("s5_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_pipe_unit.md
Name: gate_pipe_unit

Overview:
Parametrised, pipelined successor to the single two-input gate cell. Applies one of eight bitwise logic operations to two WIDTH-bit operands per transaction. Uses valid/ready handshakes on both sides and STAGES register stages. Keeps saturating statistics counters. It sits between the tile's input pins and uo_out, replacing the fixed combinational gate in the tile top.

Parameters:
WIDTH, 8, operand/result width in bits (1..32)
STAGES, 2, pipeline depth in register stages (1..4); equals input-to-output latency
CNT_W, 16, width of statistics counters (4..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand transaction offered
in_ready  output  1  unit accepts a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select, sampled with a/b
out_valid  output  1  result present on y
out_ready  input  1  downstream accepts result
y  output  WIDTH  result
y_all  output  1  AND-reduction of y (registered with y)
y_any  output  1  OR-reduction of y (registered with y)
cnt_clr  input  1  synchronous clear of both counters
xfer_cnt  output  CNT_W  number of output transfers, saturating
ones_cnt  output  CNT_W  number of output transfers with y all-ones, saturating

Behaviour:
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A AND NOT B, 7 pass A.
- Op is computed combinationally before stage 1. Stages 2..STAGES carry the result forward unchanged.
- y_all and y_any are computed from the stage-(STAGES-1) data and registered alongside y, so they always match the current y.
- Global stall: adv = !out_valid || out_ready. When adv=1, every stage loads from its predecessor, stage-valid bits included. When adv=0, all stages hold.
- in_ready = adv (combinational). An input transfer occurs when in_valid && in_ready.
- A stage-1 valid bit loads in_valid && in_ready. Bubbles are not collapsed: the pipeline shifts as a whole.
- Latency: a transfer accepted at edge N appears with out_valid=1 after edge N+STAGES-1. That means y is visible in the cycle following edge N+STAGES-1, given no stall.
- Throughput is one result per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, y, y_all and y_any stay stable, and in_ready=0.
- An output transfer occurs when out_valid && out_ready.
- On each output transfer, xfer_cnt increments by 1. ones_cnt increments by 1 if y == all-ones. Both counters saturate at 2^CNT_W-1 and do not wrap.
- cnt_clr=1: both counters become 0 at the next edge. cnt_clr takes priority over a coincident increment. The pipeline is unaffected.
- Reset, applied at a clock edge with rst=1:
  - all stage-valid bits, out_valid, y, y_all, y_any, xfer_cnt and ones_cnt become 0;
  - in-flight transactions are discarded;
  - in_ready reads 1 during and after reset, because out_valid=0;
  - an input offered in a cycle where rst=1 is not captured.
- WIDTH=1 degenerates to the original gate function with y_all = y_any = y.
- No X-propagation from a, b or op when in_valid=0: stage data may load garbage, but out_valid gates all use of it.
- Tile top usage: WIDTH=4; a=ui_in[3:0], b=ui_in[7:4]; op from uio_in[2:0]; y on uo_out[3:0]; y_all/y_any on uo_out[4]/[5].

Test Plan:
1. WIDTH=8, STAGES=2, out_ready=1; a=8'hF0, b=8'h3C, each op 0..7 on consecutive cycles -> y sequence 30,FC,CC,CF,03,33,C0,F0 (hex), each 2 cycles after acceptance. y_any=1 for all; y_all=0 for all.
2. Back-to-back stream of 10 transfers, then out_ready=0 for 3 cycles mid-stream -> in_ready=0 and y/out_valid held during the stall. No result lost or duplicated; xfer_cnt=10 at end.
3. a=8'hFF, b=8'hFF, op=0 for 5 transfers, then op=2 for 3 transfers -> ones_cnt=5, xfer_cnt=8. Second group's y=00 with y_all=0, y_any=0.
4. CNT_W=4: 20 all-ones transfers -> both counters stop at 15. Then cnt_clr on the same cycle as a transfer -> both read 0 next cycle.
5. Accept 2 transactions, assert rst for 1 cycle before they emerge -> out_valid stays 0 afterwards, counters 0, in_ready=1. A new transfer after reset emerges normally with latency 2.
6. STAGES=1 and STAGES=4 builds with the scenario 1 stimulus -> same y sequence at latency 1 and 4 respectively.
